// File: rtl/rx_cmd_pkg.sv
// Shared constants and types for the I2C receive command parser.
// Command codes, FSM state encoding and header geometry.
package rx_cmd_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned LANE_W       = 2;
  localparam int unsigned HEADER_BYTES = 80;
  localparam int unsigned CNT_W        = 7;
  localparam int unsigned HEADER_WORDS = HEADER_BYTES / 4;
  localparam int unsigned WADDR_W      = 5;

  localparam logic [BYTE_W-1:0] CMD_LOAD_HEADER = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_START       = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_STATUS      = 8'h03;
  localparam logic [BYTE_W-1:0] CMD_SOFT_RESET  = 8'h04;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    PAYLOAD = 2'd2,
    DISCARD = 2'd3
  } state_e;

endpackage

// File: rtl/rx_word_packer.sv
// Packs a byte stream big-endian into 32-bit words and emits one
// registered write strobe per completed word with an incrementing address.
module rx_word_packer
  import rx_cmd_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear_i,
  input  logic               byte_valid_i,
  input  logic [BYTE_W-1:0]  byte_i,
  output logic [WORD_W-1:0]  word_o,
  output logic [WADDR_W-1:0] word_addr_o,
  output logic               word_we_o
);

  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [WADDR_W-1:0] idx_q, idx_d;
  logic [WADDR_W-1:0] addr_q, addr_d;
  logic               we_q, we_d;

  // Lane 3 completes a word; the shift register then holds it for the write cycle.
  always_comb begin
    shift_d = shift_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    if (clear_i) begin
      shift_d = '0;
      lane_d  = '0;
      idx_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[WORD_W-BYTE_W-1:0], byte_i};
      lane_d  = lane_q + LANE_W'(1);
      if (lane_q == LANE_W'(3)) begin
        we_d   = 1'b1;
        addr_d = idx_q;
        idx_d  = idx_q + WADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_q <= '0;
      lane_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      shift_q <= shift_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
    end
  end

  assign word_o      = shift_q;
  assign word_addr_o = addr_q;
  assign word_we_o   = we_q;

endmodule

// File: rtl/rx_cmd_parser.sv
// Frames I2C receive bytes into host commands: header load into the word
// buffer, start/status/soft-reset pulses and frame error reporting.
module rx_cmd_parser
  import rx_cmd_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               rx_valid,
  input  logic [BYTE_W-1:0]  rx_byte,
  input  logic               frame_start,
  input  logic               frame_stop,
  input  logic               core_ready,
  output logic [WORD_W-1:0]  word_out,
  output logic [WADDR_W-1:0] word_addr,
  output logic               word_we,
  output logic               start_hash,
  output logic               status_req,
  output logic               soft_rst,
  output logic               header_loaded,
  output logic               frame_error
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             header_loaded_q, header_loaded_d;
  logic             start_hash_q, start_hash_d;
  logic             status_req_q, status_req_d;
  logic             soft_rst_q, soft_rst_d;
  logic             frame_error_q, frame_error_d;
  logic             pack_valid_c;

  // Next state: frame_start wins outright; otherwise the byte is handled
  // first and frame_stop is judged on the post-byte count.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    header_loaded_d = header_loaded_q;
    start_hash_d    = 1'b0;
    status_req_d    = 1'b0;
    soft_rst_d      = 1'b0;
    frame_error_d   = 1'b0;
    pack_valid_c    = 1'b0;

    if (frame_start) begin
      state_d = CMD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        CMD: begin
          if (rx_valid) begin
            state_d = DISCARD;
            case (rx_byte)
              CMD_LOAD_HEADER: begin
                header_loaded_d = 1'b0;
                state_d         = PAYLOAD;
              end
              CMD_START: begin
                if (header_loaded_q && core_ready) start_hash_d = 1'b1;
                else                               frame_error_d = 1'b1;
              end
              CMD_STATUS:     status_req_d = 1'b1;
              CMD_SOFT_RESET: begin
                soft_rst_d      = 1'b1;
                header_loaded_d = 1'b0;
              end
              default:        frame_error_d = 1'b1;
            endcase
          end
        end
        PAYLOAD: begin
          if (rx_valid) begin
            pack_valid_c = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(HEADER_BYTES)) begin
              header_loaded_d = 1'b1;
              state_d         = DISCARD;
            end
          end
        end
        DISCARD: begin
          if (rx_valid) frame_error_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (frame_stop) begin
        if (state_q == PAYLOAD && cnt_d < CNT_W'(HEADER_BYTES)) frame_error_d = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      header_loaded_q <= 1'b0;
      start_hash_q    <= 1'b0;
      status_req_q    <= 1'b0;
      soft_rst_q      <= 1'b0;
      frame_error_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      header_loaded_q <= header_loaded_d;
      start_hash_q    <= start_hash_d;
      status_req_q    <= status_req_d;
      soft_rst_q      <= soft_rst_d;
      frame_error_q   <= frame_error_d;
    end
  end

  rx_word_packer u_packer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear_i      (frame_start),
    .byte_valid_i (pack_valid_c),
    .byte_i       (rx_byte),
    .word_o       (word_out),
    .word_addr_o  (word_addr),
    .word_we_o    (word_we)
  );

  assign start_hash    = start_hash_q;
  assign status_req    = status_req_q;
  assign soft_rst      = soft_rst_q;
  assign header_loaded = header_loaded_q;
  assign frame_error   = frame_error_q;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Directed bench for rx_cmd_parser: header loads, commands, framing errors
// and asynchronous reset, with hand-computed expectations.
module tb_rx_cmd_parser;

  logic        clk;
  logic        n_rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        frame_start;
  logic        frame_stop;
  logic        core_ready;
  logic [31:0] word_out;
  logic [4:0]  word_addr;
  logic        word_we;
  logic        start_hash;
  logic        status_req;
  logic        soft_rst;
  logic        header_loaded;
  logic        frame_error;

  int total = 0;
  int bad   = 0;

  int          we_cnt, fe_cnt, sh_cnt, sr_cnt, srst_cnt;
  logic [31:0] mem [0:31];
  logic        hl_at_we [0:31];

  rx_cmd_parser dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .rx_valid      (rx_valid),
    .rx_byte       (rx_byte),
    .frame_start   (frame_start),
    .frame_stop    (frame_stop),
    .core_ready    (core_ready),
    .word_out      (word_out),
    .word_addr     (word_addr),
    .word_we       (word_we),
    .start_hash    (start_hash),
    .status_req    (status_req),
    .soft_rst      (soft_rst),
    .header_loaded (header_loaded),
    .frame_error   (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (word_we) begin
      we_cnt = we_cnt + 1;
      mem[word_addr]      = word_out;
      hl_at_we[word_addr] = header_loaded;
    end
    if (frame_error) fe_cnt   = fe_cnt + 1;
    if (start_hash)  sh_cnt   = sh_cnt + 1;
    if (status_req)  sr_cnt   = sr_cnt + 1;
    if (soft_rst)    srst_cnt = srst_cnt + 1;
  end

  task automatic clr_counts();
    we_cnt = 0; fe_cnt = 0; sh_cnt = 0; sr_cnt = 0; srst_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'h0;
      hl_at_we[i] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_stop();
    frame_stop = 1'b1;
    @(negedge clk);
    frame_stop = 1'b0;
  endtask

  task automatic load_header(input logic [7:0] base);
    pulse_start();
    send_byte(8'h01);
    for (int i = 0; i < 80; i++) send_byte(8'(base + 8'(i)));
    pulse_stop();
    idle(2);
  endtask

  task automatic test_reset();
    logic [43:0] outs;
    n_rst = 1'b0;
    idle(2);
    n_rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      outs = {word_out, word_addr, word_we, start_hash, status_req, soft_rst, header_loaded, frame_error};
      total++;
      if (outs !== 44'h0) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d got %h expected 0", c, outs);
      end
    end
    clr_counts();
    send_byte(8'hAA);
    idle(3);
    total++;
    if ((fe_cnt + sh_cnt + sr_cnt + srst_cnt + we_cnt) !== 0) begin
      bad++;
      $display("FAIL idle_stray_byte got %0d pulses expected 0", fe_cnt + sh_cnt + sr_cnt + srst_cnt + we_cnt);
    end
  endtask

  task automatic test_full_load();
    clr_counts();
    pulse_start();
    send_byte(8'h01);
    for (int i = 0; i < 80; i++) begin
      send_byte(8'(i));
      if (i == 3) begin
        total++;
        if (word_we !== 1'b1 || word_out !== 32'h00010203 || word_addr !== 5'd0) begin
          bad++;
          $display("FAIL first_word_latency got we=%b word=%h addr=%0d expected we=1 word=00010203 addr=0",
                   word_we, word_out, word_addr);
        end
      end
    end
    pulse_stop();
    idle(2);
    total++;
    if (we_cnt !== 20) begin bad++; $display("FAIL full_we_count got %0d expected 20", we_cnt); end
    total++;
    if (mem[0] !== 32'h00010203) begin bad++; $display("FAIL full_word0 got %h expected 00010203", mem[0]); end
    total++;
    if (mem[19] !== 32'h4C4D4E4F) begin bad++; $display("FAIL full_word19 got %h expected 4c4d4e4f", mem[19]); end
    total++;
    if (mem[10] !== 32'h28292A2B) begin bad++; $display("FAIL full_word10 got %h expected 28292a2b", mem[10]); end
    total++;
    if (hl_at_we[19] !== 1'b1 || hl_at_we[18] !== 1'b0) begin
      bad++;
      $display("FAIL hl_timing got hl@18=%b hl@19=%b expected 0 1", hl_at_we[18], hl_at_we[19]);
    end
    total++;
    if (fe_cnt !== 0) begin bad++; $display("FAIL full_no_error got %0d expected 0", fe_cnt); end
    total++;
    if (header_loaded !== 1'b1) begin bad++; $display("FAIL full_hl got %b expected 1", header_loaded); end
  endtask

  task automatic test_short_load();
    clr_counts();
    pulse_start();
    send_byte(8'h01);
    total++;
    if (header_loaded !== 1'b0) begin bad++; $display("FAIL short_hl_cleared got %b expected 0", header_loaded); end
    for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + 8'(i)));
    pulse_stop();
    total++;
    if (frame_error !== 1'b1) begin bad++; $display("FAIL short_stop_error got %b expected 1", frame_error); end
    idle(2);
    total++;
    if (we_cnt !== 2) begin bad++; $display("FAIL short_we_count got %0d expected 2", we_cnt); end
    total++;
    if (mem[1] !== 32'h14151617) begin bad++; $display("FAIL short_word1 got %h expected 14151617", mem[1]); end
    total++;
    if (fe_cnt !== 1) begin bad++; $display("FAIL short_fe_count got %0d expected 1", fe_cnt); end
    total++;
    if (header_loaded !== 1'b0) begin bad++; $display("FAIL short_hl got %b expected 0", header_loaded); end
  endtask

  task automatic test_start_cmd();
    load_header(8'h80);
    clr_counts();
    core_ready = 1'b1;
    pulse_start();
    send_byte(8'h02);
    total++;
    if (start_hash !== 1'b1 || frame_error !== 1'b0) begin
      bad++;
      $display("FAIL start_ready got sh=%b fe=%b expected 1 0", start_hash, frame_error);
    end
    @(negedge clk);
    total++;
    if (start_hash !== 1'b0) begin bad++; $display("FAIL start_pulse_width got %b expected 0", start_hash); end
    pulse_stop();
    core_ready = 1'b0;
    pulse_start();
    send_byte(8'h02);
    total++;
    if (start_hash !== 1'b0 || frame_error !== 1'b1) begin
      bad++;
      $display("FAIL start_not_ready got sh=%b fe=%b expected 0 1", start_hash, frame_error);
    end
    pulse_stop();
    idle(2);
    total++;
    if (sh_cnt !== 1 || fe_cnt !== 1) begin
      bad++;
      $display("FAIL start_counts got sh=%0d fe=%0d expected 1 1", sh_cnt, fe_cnt);
    end
    core_ready = 1'b1;
  endtask

  task automatic test_overlong();
    clr_counts();
    pulse_start();
    send_byte(8'h01);
    for (int i = 0; i < 80; i++) send_byte(8'(i));
    send_byte(8'hE0);
    send_byte(8'hE1);
    pulse_stop();
    idle(2);
    total++;
    if (fe_cnt !== 2) begin bad++; $display("FAIL overlong_fe got %0d expected 2", fe_cnt); end
    total++;
    if (we_cnt !== 20 || header_loaded !== 1'b1) begin
      bad++;
      $display("FAIL overlong_state got we=%0d hl=%b expected 20 1", we_cnt, header_loaded);
    end
  endtask

  task automatic test_stop_with_last();
    clr_counts();
    pulse_start();
    send_byte(8'h01);
    for (int i = 0; i < 79; i++) send_byte(8'(8'h20 + 8'(i)));
    frame_stop = 1'b1;
    send_byte(8'h6F);
    frame_stop = 1'b0;
    idle(2);
    send_byte(8'h55);
    idle(2);
    total++;
    if (fe_cnt !== 0) begin bad++; $display("FAIL stop_last_fe got %0d expected 0", fe_cnt); end
    total++;
    if (we_cnt !== 20 || header_loaded !== 1'b1) begin
      bad++;
      $display("FAIL stop_last_state got we=%0d hl=%b expected 20 1", we_cnt, header_loaded);
    end
    total++;
    if (mem[19] !== 32'h6C6D6E6F) begin bad++; $display("FAIL stop_last_word19 got %h expected 6c6d6e6f", mem[19]); end
  endtask

  task automatic test_illegal_soft();
    clr_counts();
    pulse_start();
    send_byte(8'h7E);
    total++;
    if (frame_error !== 1'b1) begin bad++; $display("FAIL illegal_cmd got %b expected 1", frame_error); end
    pulse_stop();
    pulse_start();
    send_byte(8'h03);
    total++;
    if (status_req !== 1'b1 || header_loaded !== 1'b1) begin
      bad++;
      $display("FAIL status_cmd got sr=%b hl=%b expected 1 1", status_req, header_loaded);
    end
    pulse_stop();
    pulse_start();
    send_byte(8'h04);
    total++;
    if (soft_rst !== 1'b1 || header_loaded !== 1'b0) begin
      bad++;
      $display("FAIL soft_reset got srst=%b hl=%b expected 1 0", soft_rst, header_loaded);
    end
    pulse_stop();
    idle(2);
    total++;
    if (fe_cnt !== 1 || sr_cnt !== 1 || srst_cnt !== 1) begin
      bad++;
      $display("FAIL cmd_counts got fe=%0d sr=%0d srst=%0d expected 1 1 1", fe_cnt, sr_cnt, srst_cnt);
    end
  endtask

  task automatic test_start_priority();
    clr_counts();
    pulse_start();
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + 8'(i)));
    frame_start = 1'b1;
    send_byte(8'hEE);
    frame_start = 1'b0;
    send_byte(8'h03);
    total++;
    if (status_req !== 1'b1) begin bad++; $display("FAIL restart_status got %b expected 1", status_req); end
    pulse_stop();
    idle(2);
    total++;
    if (we_cnt !== 1 || fe_cnt !== 0) begin
      bad++;
      $display("FAIL restart_counts got we=%0d fe=%0d expected 1 0", we_cnt, fe_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [43:0] outs;
    load_header(8'h00);
    clr_counts();
    pulse_start();
    send_byte(8'h03);
    #2 n_rst = 1'b0;
    #1;
    total++;
    if (header_loaded !== 1'b0) begin bad++; $display("FAIL reset_clears_hl got %b expected 0", header_loaded); end
    @(negedge clk);
    n_rst = 1'b1;
    clr_counts();
    pulse_start();
    send_byte(8'h01);
    for (int i = 0; i < 3; i++) send_byte(8'(8'h30 + 8'(i)));
    rx_valid = 1'b1;
    rx_byte  = 8'h33;
    #2 n_rst = 1'b0;
    #1;
    outs = {word_out, word_addr, word_we, start_hash, status_req, soft_rst, header_loaded, frame_error};
    total++;
    if (outs !== 44'h0) begin bad++; $display("FAIL midframe_reset got %h expected 0", outs); end
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    send_byte(8'h44);
    idle(3);
    total++;
    if (we_cnt !== 0 || fe_cnt !== 0 || word_out !== 32'h0) begin
      bad++;
      $display("FAIL post_reset_idle got we=%0d fe=%0d word=%h expected 0 0 0", we_cnt, fe_cnt, word_out);
    end
  endtask

  initial begin
    n_rst       = 1'b0;
    rx_valid    = 1'b0;
    rx_byte     = 8'h00;
    frame_start = 1'b0;
    frame_stop  = 1'b0;
    core_ready  = 1'b1;
    clr_counts();
    @(negedge clk);
    test_reset();
    test_full_load();
    test_short_load();
    test_start_cmd();
    test_overlong();
    test_stop_with_last();
    test_illegal_soft();
    test_start_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_cmd_parser.md
Name: rx_cmd_parser

Overview:
- Consumes the byte stream held by the I2C receive register and interprets it as framed host commands.
- First byte after an I2C start is the command; LOAD_HEADER payload bytes are packed big-endian into 32-bit words and written into the Scrypt header buffer.
- Issues single-cycle control pulses (start hash, status request, soft reset) to the mining core and the Tx path.
- Sits between the Rx byte register (upstream) and the header RAM/core controller (downstream).

Parameters:
- HEADER_BYTES, 80, LOAD_HEADER payload length in bytes; must be a multiple of 4.
- CNT_W, 7, byte counter width; must satisfy 2**CNT_W > HEADER_BYTES.

Ports:
- clk  in  1  system clock, all state on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_byte holds a newly received byte (driven from load_rx delayed one cycle).
- rx_byte  in  8  received byte (Rx register output).
- frame_start  in  1  one-cycle pulse: I2C start/repeated start addressed to us.
- frame_stop  in  1  one-cycle pulse: I2C stop.
- core_ready  in  1  hash core idle and able to accept a start.
- word_out  out  32  packed header word, big-endian (first byte in [31:24]).
- word_addr  out  5  header word index 0..HEADER_BYTES/4-1.
- word_we  out  1  one-cycle write strobe for word_out/word_addr.
- start_hash  out  1  one-cycle pulse to the core.
- status_req  out  1  one-cycle pulse to the Tx path.
- soft_rst  out  1  one-cycle pulse to the core.
- header_loaded  out  1  level: a complete header is in the buffer.
- frame_error  out  1  one-cycle error pulse.

Behaviour:
- Reset: every output 0; state IDLE; byte counter 0; packing shift register 0.
- Command codes: 0x01 LOAD_HEADER, 0x02 START, 0x03 STATUS, 0x04 SOFT_RESET; any other code is illegal.
- States: IDLE, CMD, PAYLOAD, DISCARD.
- frame_start, from any state: go to CMD, clear counter. This is highest priority; a coincident rx_valid is ignored.
- IDLE: rx_valid is ignored.
- CMD, on rx_valid, by command byte:
  - 0x01: clear header_loaded; go to PAYLOAD.
  - 0x02: if header_loaded && core_ready, pulse start_hash next cycle; otherwise pulse frame_error. Either way go to DISCARD.
  - 0x03: pulse status_req; go to DISCARD.
  - 0x04: pulse soft_rst; clear header_loaded; go to DISCARD.
  - Illegal code: pulse frame_error; go to DISCARD.
- PAYLOAD, on each rx_valid:
  - Shift the byte into the packer (shift left by 8, byte into [7:0]) and increment the counter.
  - Byte count 4k (k = 1..20): the cycle after that rx_valid, word_we=1, word_out=packed word, word_addr=k-1.
  - Byte count HEADER_BYTES: set header_loaded one cycle after that rx_valid (same cycle as the last word_we); go to DISCARD.
- DISCARD: every rx_valid pulses frame_error (overlong frame) and the byte is dropped.
- frame_stop:
  - In PAYLOAD with count < HEADER_BYTES: pulse frame_error; header_loaded stays 0; go to IDLE.
  - In all other states: go to IDLE silently.
- rx_valid and frame_stop in the same cycle: the byte is processed first, then stop is evaluated on the post-byte count. The 80th byte arriving with stop is a good frame.
- Partial words are never written; the counter never wraps (saturates by leaving PAYLOAD).
- Every output pulse is registered: exactly one cycle wide, one cycle after the causing input.
- header_loaded persists across frames until the next LOAD_HEADER command byte or SOFT_RESET.
- Async reset mid-frame returns to IDLE and clears header_loaded; no word_we is emitted.

Decomposition:
- Package rx_cmd_pkg holds:
  - command code constants CMD_LOAD_HEADER, CMD_START, CMD_STATUS, CMD_SOFT_RESET (8-bit);
  - the state typedef enum (IDLE, CMD, PAYLOAD, DISCARD);
  - HEADER_WORDS = HEADER_BYTES/4.
- One sub-module, rx_word_packer: 4-byte shift register, 2-bit lane counter, word_we/word_out generation, clear input.
- The FSM, counter, header_loaded and control pulses stay in rx_cmd_parser.

Test Plan:
- Reset release, idle -> all outputs 0 for 10 cycles; stray rx_valid 0xAA in IDLE yields no pulses.
- start, 0x01, bytes 0x00..0x4F, stop -> 20 word_we; word 0 = 0x00010203 at addr 0, word 19 = 0x4C4D4E4F at addr 19; header_loaded=1 with the last word_we; no frame_error.
- start, 0x01, 10 bytes, stop -> 2 word_we (addr 0,1), one frame_error on stop, header_loaded=0.
- After a good load with core_ready=1: start, 0x02, stop -> start_hash pulse 1 cycle after the command byte. Repeat with core_ready=0 -> frame_error, no start_hash.
- start, 0x01, 80 bytes, then 2 extra bytes -> two frame_error pulses; header_loaded remains 1.
- start, 0x7E -> frame_error. Then start, 0x04 -> soft_rst pulse and header_loaded cleared. Assert n_rst low mid-payload -> all outputs 0 immediately, state IDLE.
